// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - request, ALU and result/status signals of the ALU issue stage
interface alu_issue_stage_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    // request channel
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // ALU side
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    // result channel
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_overflow;
    logic             out_illegal;

    // statistics
    logic             clr_stats;
    logic             sticky_ovf;
    logic [CNT_W-1:0] ovf_count;

    // environment side: issues requests, models the ALU, consumes results
    modport master (
        output in_valid, in_op, in_a, in_b,
        input  in_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero, alu_overflow,
        input  out_valid, out_op, out_result, out_zero, out_overflow, out_illegal,
        output out_ready,
        output clr_stats,
        input  sticky_ovf, ovf_count
    );

    // issue stage side
    modport slave (
        input  in_valid, in_op, in_a, in_b,
        output in_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero, alu_overflow,
        output out_valid, out_op, out_result, out_zero, out_overflow, out_illegal,
        input  out_ready,
        input  clr_stats,
        output sticky_ovf, ovf_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage valid/ready pipeline around the combinational 4-bit ALU
module alu_issue_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_stage_if.slave  bus
);
    localparam logic [2:0] OP_ILLEGAL = 3'b101;

    // stage 1: accepted request, drives the ALU
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // stage 2: captured ALU outputs awaiting the consumer
    logic             s2_valid;
    logic [2:0]       s2_op;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_ovf;
    logic             s2_illegal;

    logic             sticky_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    logic s2_load;
    logic in_ready_int;
    logic in_fire;
    logic out_fire;
    logic s1_illegal;

    assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
    assign in_ready_int = !s1_valid || s2_load;
    assign in_fire      = bus.in_valid && in_ready_int;
    assign out_fire     = s2_valid && bus.out_ready;
    assign s1_illegal   = (s1_op == OP_ILLEGAL);

    assign bus.in_ready     = in_ready_int;
    assign bus.alu_a        = s1_a;
    assign bus.alu_b        = s1_b;
    assign bus.alu_op       = s1_op;
    assign bus.out_valid    = s2_valid;
    assign bus.out_op       = s2_op;
    assign bus.out_result   = s2_result;
    assign bus.out_zero     = s2_zero;
    assign bus.out_overflow = s2_ovf;
    assign bus.out_illegal  = s2_illegal;
    assign bus.sticky_ovf   = sticky_q;
    assign bus.ovf_count    = ovf_cnt_q;

    // stage 1: take a new request, or empty once its contents move to stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.in_op;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // stage 2: capture the ALU outputs (squashed for the unassigned op), hold until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_op      <= '0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s2_load) begin
            s2_valid   <= 1'b1;
            s2_op      <= s1_op;
            s2_result  <= s1_illegal ? '0 : bus.alu_result;
            s2_zero    <= s1_illegal ? 1'b0 : bus.alu_zero;
            s2_ovf     <= s1_illegal ? 1'b0 : bus.alu_overflow;
            s2_illegal <= s1_illegal;
        end else if (out_fire) begin
            s2_valid   <= 1'b0;
        end
    end

    // overflow statistics on delivered results; an explicit clear takes priority
    always_ff @(posedge clk) begin
        if (reset || bus.clr_stats) begin
            sticky_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (out_fire && s2_ovf) begin
            sticky_q <= 1'b1;
            if (ovf_cnt_q != {CNT_W{1'b1}}) begin
                ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic clk;
    logic reset;

    alu_issue_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] res;
        logic       z;
        logic       v;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural alu_4bit; unassigned op yields junk the stage must squash
    logic [3:0] sum_w, diff_w;
    always_comb begin
        sum_w            = bus.alu_a + bus.alu_b;
        diff_w           = bus.alu_a - bus.alu_b;
        bus.alu_result   = 4'h0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_op)
            3'b000: bus.alu_result = bus.alu_a & bus.alu_b;
            3'b001: bus.alu_result = bus.alu_a | bus.alu_b;
            3'b010: begin
                bus.alu_result   = sum_w;
                bus.alu_overflow = (bus.alu_a[3] == bus.alu_b[3]) && (sum_w[3] != bus.alu_a[3]);
            end
            3'b011: bus.alu_result = ~(bus.alu_a & bus.alu_b);
            3'b100: bus.alu_result = ~(bus.alu_a | bus.alu_b);
            3'b110: begin
                bus.alu_result   = diff_w;
                bus.alu_overflow = (bus.alu_a[3] != bus.alu_b[3]) && (diff_w[3] != bus.alu_a[3]);
            end
            3'b111: begin
                bus.alu_result   = {3'b000, diff_w[3]};
                bus.alu_overflow = (bus.alu_a[3] != bus.alu_b[3]) && (diff_w[3] != bus.alu_a[3]);
            end
            default: begin
                bus.alu_result   = 4'hA;
                bus.alu_overflow = 1'b1;
            end
        endcase
        bus.alu_zero = (bus.alu_result == 4'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare every delivered result against the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_delivery", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_op",       {29'd0, bus.out_op},     {29'd0, e.op});
                chk("out_result",   {28'd0, bus.out_result}, {28'd0, e.res});
                chk("out_zero",     {31'd0, bus.out_zero},     {31'd0, e.z});
                chk("out_overflow", {31'd0, bus.out_overflow}, {31'd0, e.v});
                chk("out_illegal",  {31'd0, bus.out_illegal},  {31'd0, e.ill});
            end
        end
    end

    // offer a request until accepted; returns cycles spent waiting
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic z, input logic v, input logic ill,
                        output int waited);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            e.op = op; e.res = res; e.z = z; e.v = v; e.ill = ill;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int w;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.out_ready = 1'b0;
        bus.clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu_a",     {28'd0, bus.alu_a},     32'd0);
        chk("rst_alu_b",     {28'd0, bus.alu_b},     32'd0);
        chk("rst_alu_op",    {29'd0, bus.alu_op},    32'd0);
        chk("rst_sticky",    {31'd0, bus.sticky_ovf}, 32'd0);
        chk("rst_count",     {30'd0, bus.ovf_count},  32'd0);
        @(posedge clk);
        #1;

        // 1: single overflowing ADD, latency 2
        bus.out_ready = 1'b1;
        send(3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, w);
        chk("t1_valid_n1",  {31'd0, bus.out_valid}, 32'd0);
        chk("t1_alu_a",     {28'd0, bus.alu_a},  32'h7);
        chk("t1_alu_b",     {28'd0, bus.alu_b},  32'h1);
        chk("t1_alu_op",    {29'd0, bus.alu_op}, 32'h2);
        @(posedge clk);
        #1;
        chk("t1_valid_n2",  {31'd0, bus.out_valid}, 32'd1);
        chk("t1_result",    {28'd0, bus.out_result}, 32'h8);
        @(posedge clk);
        #1;
        chk("t1_sticky",    {31'd0, bus.sticky_ovf}, 32'd1);
        chk("t1_count",     {30'd0, bus.ovf_count},  32'd1);

        // 2: back-to-back with out_ready = 1
        send(3'b000, 4'b0111, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, w);
        chk("t2_wait0", w, 32'd0);
        send(3'b110, 4'b1111, 4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0, w);
        chk("t2_wait1", w, 32'd0);
        send(3'b111, 4'b1101, 4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0, w);
        chk("t2_wait2", w, 32'd0);
        drain();
        chk("t2_count", {30'd0, bus.ovf_count}, 32'd2);

        // 3: stall with three requests offered
        bus.out_ready = 1'b0;
        send(3'b001, 4'b0001, 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b0, w);
        send(3'b010, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, w);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b100;
        bus.in_a     = 4'b0000;
        bus.in_b     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", {31'd0, bus.in_ready},  32'd0);
            chk("t3_hold_valid",   {31'd0, bus.out_valid}, 32'd1);
            chk("t3_hold_result",  {28'd0, bus.out_result}, 32'h3);
            chk("t3_hold_op",      {29'd0, bus.out_op},     32'h1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(3'b100, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, w);
        drain();
        chk("t3_count", {30'd0, bus.ovf_count}, 32'd2);

        // 4: unassigned op is squashed and leaves stats alone
        send(3'b101, 4'b0101, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, w);
        drain();
        chk("t4_count",  {30'd0, bus.ovf_count},  32'd2);
        chk("t4_sticky", {31'd0, bus.sticky_ovf}, 32'd1);

        // 5: saturation, then clear racing an overflow delivery
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b0;
        chk("t5_cleared", {30'd0, bus.ovf_count}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, w);
        end
        drain();
        chk("t5_saturated", {30'd0, bus.ovf_count},  32'd3);
        chk("t5_sticky",    {31'd0, bus.sticky_ovf}, 32'd1);
        bus.out_ready = 1'b0;
        send(3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, w);
        @(posedge clk);
        #1;
        chk("t5_pending", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b0;
        chk("t5_clr_count",  {30'd0, bus.ovf_count},  32'd0);
        chk("t5_clr_sticky", {31'd0, bus.sticky_ovf}, 32'd0);

        // 6: reset one cycle after an accept drops the request
        send(3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, w);
        drain();
        bus.out_ready = 1'b0;
        send(3'b010, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b0, w);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("t6_alu_a",     {28'd0, bus.alu_a},     32'd0);
        chk("t6_alu_b",     {28'd0, bus.alu_b},     32'd0);
        chk("t6_alu_op",    {29'd0, bus.alu_op},    32'd0);
        chk("t6_count",     {30'd0, bus.ovf_count},  32'd0);
        chk("t6_sticky",    {31'd0, bus.sticky_ovf}, 32'd0);
        sb.delete();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_ghost", {31'd0, bus.out_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
